// File: rtl/lsb_rca_16_pkg.sv
// Shared constants for the least-significant half of the 32-bit adder datapath.
// Optional input registering is selected with the LSB_RCA_INREG_EN macro.
package lsb_rca_16_pkg;

    // Full datapath width; the LSB adder covers its lower half.
    localparam int DP_WIDTH  = 32;
    localparam int LSB_WIDTH = DP_WIDTH / 2;

    // Operand widths are built from whole nibbles.
    localparam int NIBBLE    = 4;

    // Legal operand width: a multiple of a nibble and at least one nibble.
    function automatic bit width_ok(input int w);
        return (w >= NIBBLE) && ((w % NIBBLE) == 0);
    endfunction

endpackage

// File: rtl/rca_fa_cell.sv
// One-bit full adder cell used as a link in the explicit ripple chain.
// Carry-out is the majority of the three inputs.
module rca_fa_cell
    import lsb_rca_16_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/lsb_rca_16.sv
// Registered ripple-carry adder for the LSB half of the datapath sum.
// Define LSB_RCA_INREG_EN to register a, b and c_in ahead of the ripple chain.
module lsb_rca_16
    import lsb_rca_16_pkg::*;
#(
    parameter int WIDTH = LSB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             c_out,
    output logic [WIDTH-1:0] s
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("lsb_rca_16: WIDTH must be a multiple of 4 and >= 4");
    end

    // Operands as seen by the ripple chain.
    logic [WIDTH-1:0] a_core;
    logic [WIDTH-1:0] b_core;
    logic             ci_core;

`ifdef LSB_RCA_INREG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             ci_q;

    // Input stage isolates the ripple path from upstream logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            ci_q <= 1'b0;
        end else begin
            a_q  <= a;
            b_q  <= b;
            ci_q <= c_in;
        end
    end

    assign a_core  = a_q;
    assign b_core  = b_q;
    assign ci_core = ci_q;
`else
    assign a_core  = a;
    assign b_core  = b;
    assign ci_core = c_in;
`endif

    // Explicit carry chain: carry[i] enters bit i, carry[WIDTH] leaves the top.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = ci_core;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rca_fa_cell u_fa (
            .a  (a_core[i]),
            .b  (b_core[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             c_out_d;
    logic             c_out_q;

    // Next-state for the output register is the raw ripple result.
    always_comb begin
        s_d     = sum;
        c_out_d = carry[WIDTH];
    end

    // Output register; reset clears the result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_out_q <= c_out_d;
        end
    end

    assign s     = s_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_lsb_rca_16.sv
// Self-checking bench for lsb_rca_16 against an arithmetic reference model.
// Latency follows LSB_RCA_INREG_EN (1 cycle, or 2 when defined).
module tb_lsb_rca_16;

    localparam int W = 16;
`ifdef LSB_RCA_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         c_out;
    logic [W-1:0] s;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W:0] exp_q[$];

    lsb_rca_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .c_out (c_out),
        .s     (s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] got,
                         input logic [W:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic ci);
        int unsigned t;
        t = int'(x) + int'(y) + (ci ? 1 : 0);
        return t[W:0];
    endfunction

    // Results still inside the pipe after reset are zero.
    task automatic preload();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
    endtask

    task automatic cycle(input string tag, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci);
        logic [W:0] want;
        @(negedge clk);
        a    = x;
        b    = y;
        c_in = ci;
        exp_q.push_back(ref_sum(x, y, ci));
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(tag, {c_out, s}, want);
    endtask

    initial begin
        rst_n = 1'b1;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_state", {c_out, s}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        preload();

        cycle("zero",       16'h0000, 16'h0000, 1'b0);
        cycle("cin_inc",    16'h3FE9, 16'h0000, 1'b1);
        cycle("back_zero",  16'h0000, 16'h0000, 1'b0);
        cycle("wrap",       16'hFFFF, 16'h0001, 1'b0);
        cycle("all_ones",   16'hFFFF, 16'hFFFF, 1'b1);
        cycle("msb_carry",  16'h8000, 16'h8000, 1'b0);
        cycle("alt",        16'hAAAA, 16'h5555, 1'b1);
        cycle("alt_nc",     16'hAAAA, 16'h5555, 1'b0);
        for (int i = 0; i < LAT; i++)
            cycle("drain",  16'h0000, 16'h0000, 1'b0);

        for (int i = 0; i < 1000; i++)
            cycle("random", W'($urandom), W'($urandom), 1'($urandom));

        for (int i = 0; i < LAT + 1; i++)
            cycle("hold_ffff", 16'hFFFF, 16'h0000, 1'b0);
        check("pre_reset_s", {1'b0, s}, {1'b0, 16'hFFFF});

        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {c_out, s}, '0);
        @(posedge clk);
        #1;
        check("reset_held", {c_out, s}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        preload();

        cycle("restart_0",  16'h1234, 16'h4321, 1'b1);
        cycle("restart_1",  16'hF000, 16'h1000, 1'b1);
        for (int i = 0; i < LAT; i++)
            cycle("restart_d", 16'h0000, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
